fifo_rr_drain_arb: RTL and testbench

// Round-robin read scheduler that drains NUM_CH showahead FIFOs (SHOWAHEAD="ON" fifo

---
 rtl/fifo_rr_drain_arb.sv | 142 ++++++++++++++
 tb/tb_fifo_rr_drain_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain_arb.sv
// Round-robin drain scheduler for NUM_CH showahead FIFOs.
// One channel is granted at a time for up to MAX_BURST words. Popped words land in
// a registered valid/ready output stage. After every burst the FSM passes through
// IDLE for exactly one cycle to pick the next channel. The scan for the next channel
// starts just after the last one granted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant; scan for the next non-empty channel after last_ptr
// ST_BURST | grant held on gidx_q; pop while the channel has data and the
//          | output stage can load; leave on burst limit or drained channel
module fifo_rr_drain_arb #(
   parameter int NUM_CH    = 4,
   parameter int DWIDTH    = 16,
   parameter int MAX_BURST = 4,
   localparam int CH_W     = $clog2(NUM_CH),
   localparam int BCNT_W   = $clog2(MAX_BURST + 1)
) (
   input  logic                       clk_i,
   input  logic                       srst_i,
   input  logic [NUM_CH-1:0]          ch_empty_i,
   input  logic [NUM_CH*DWIDTH-1:0]   ch_q_i,
   output logic [NUM_CH-1:0]          ch_rdreq_o,
   output logic [DWIDTH-1:0]          data_o,
   output logic [CH_W-1:0]            chan_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [NUM_CH-1:0]          grant_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(MAX_BURST - 1);

   state_t              state_q;
   logic [CH_W-1:0]     gidx_q;
   logic [CH_W-1:0]     last_ptr_q;
   logic [BCNT_W-1:0]   count_q;

   logic [DWIDTH-1:0]   ch_word [NUM_CH];
   logic [CH_W-1:0]     pick_idx;
   logic [CH_W-1:0]     cand_idx;
   logic                pick_found;
   logic                can_load;
   logic                gnt_empty;
   logic                pop;

   // Split the flat FIFO data bus into one word per channel.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         ch_word[k] = ch_q_i[k*DWIDTH +: DWIDTH];
      end
   end

   assign can_load  = !valid_o || ready_i;
   assign gnt_empty = ch_empty_i[gidx_q];
   // Gating with srst_i keeps rdreq low for the whole reset cycle, so a reset
   // in the middle of a burst never pops a word.
   assign pop       = srst_i && (state_q == ST_BURST) && !gnt_empty && can_load;

   // Read request goes only to the granted channel, and only on a real pop.
   always_comb begin
      ch_rdreq_o = '0;
      if (pop) begin
         ch_rdreq_o[gidx_q] = 1'b1;
      end
   end

   // Find the first non-empty channel after the last grant, wrapping modulo NUM_CH.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand_idx = CH_W'((int'(last_ptr_q) + i) % NUM_CH);
         if (!pick_found && !ch_empty_i[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Grant FSM, burst counter and registered output stage.
   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         state_q    <= ST_IDLE;
         gidx_q     <= '0;
         last_ptr_q <= CH_W'(NUM_CH - 1);
         count_q    <= '0;
         grant_o    <= '0;
         valid_o    <= 1'b0;
         data_o     <= '0;
         chan_o     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // The last word of the previous burst may still be waiting here.
               if (ready_i) begin
                  valid_o <= 1'b0;
               end
               if (pick_found) begin
                  grant_o    <= NUM_CH'(1) << pick_idx;
                  gidx_q     <= pick_idx;
                  last_ptr_q <= pick_idx;
                  count_q    <= '0;
                  state_q    <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (pop) begin
                  data_o  <= ch_word[gidx_q];
                  chan_o  <= gidx_q;
                  valid_o <= 1'b1;
                  count_q <= count_q + BCNT_W'(1);
                  if (count_q == LAST_CNT) begin
                     grant_o <= '0;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  if (ready_i) begin
                     valid_o <= 1'b0;
                  end
                  // An empty channel ends the burst only once the output stage can
                  // accept again; otherwise the grant is held.
                  if (gnt_empty && can_load) begin
                     grant_o <= '0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               grant_o <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Bench for fifo_rr_drain_arb: behavioural showahead FIFOs feed the DUT.
// A burst-level round-robin model predicts the word order and the grant order.
module tb_fifo_rr_drain_arb;

   localparam int NUM_CH    = 4;
   localparam int DWIDTH    = 16;
   localparam int MAX_BURST = 4;
   localparam int CH_W      = 2;
   localparam int DEPTH     = 64;

   logic                     clk_i = 1'b0;
   logic                     srst_i;
   logic [NUM_CH-1:0]        ch_empty_i;
   logic [NUM_CH*DWIDTH-1:0] ch_q_i;
   logic [NUM_CH-1:0]        ch_rdreq_o;
   logic [DWIDTH-1:0]        data_o;
   logic [CH_W-1:0]          chan_o;
   logic                     valid_o;
   logic                     ready_i;
   logic [NUM_CH-1:0]        grant_o;

   always #5 clk_i = ~clk_i;

   fifo_rr_drain_arb #(.NUM_CH(NUM_CH), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk_i      (clk_i),
      .srst_i     (srst_i),
      .ch_empty_i (ch_empty_i),
      .ch_q_i     (ch_q_i),
      .ch_rdreq_o (ch_rdreq_o),
      .data_o     (data_o),
      .chan_o     (chan_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .grant_o    (grant_o)
   );

   // Showahead FIFO models: the tasks write wp, the posedge process writes rp.
   logic [DWIDTH-1:0] mem [NUM_CH][DEPTH];
   int wp [NUM_CH] = '{default: 0};
   int rp [NUM_CH] = '{default: 0};

   logic [CH_W+DWIDTH-1:0] got_q [$];
   logic [CH_W+DWIDTH-1:0] exp_q [$];
   int exp_g [$];
   int got_g [$];
   int gap_q [$];
   int n_checks = 0;
   int n_fail = 0;
   int n_bad_pop = 0;
   int n_bad_grant = 0;
   int model_ptr = NUM_CH - 1;
   bit timed_out;

   always_comb begin
      ch_empty_i = '1;
      ch_q_i     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ch_empty_i[k] = (wp[k] == rp[k]);
         ch_q_i[k*DWIDTH +: DWIDTH] = mem[k][rp[k] % DEPTH];
      end
   end

   always @(posedge clk_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_rdreq_o[k]) begin
            if (wp[k] == rp[k]) n_bad_pop++;
            else rp[k] <= rp[k] + 1;
         end
      end
      if (srst_i && valid_o && ready_i) got_q.push_back({chan_o, data_o});
   end

   function automatic int oh_idx(input logic [NUM_CH-1:0] v);
      int r = -1;
      for (int k = 0; k < NUM_CH; k++) if (v[k]) r = k;
      return r;
   endfunction

   task automatic push(input int ch, input logic [DWIDTH-1:0] d);
      mem[ch][wp[ch] % DEPTH] = d;
      wp[ch] = wp[ch] + 1;
   endtask

   task automatic apply_reset();
      @(negedge clk_i);
      srst_i = 1'b0;
      @(negedge clk_i);
      srst_i = 1'b1;
      model_ptr = NUM_CH - 1;
   endtask

   // Reference: rotate from start_ptr; each grant takes min(MAX_BURST, words left).
   task automatic build_expected(input int start_ptr);
      int rem [NUM_CH];
      int pos [NUM_CH];
      int ptr, c, n, total;
      exp_q.delete();
      exp_g.delete();
      total = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         rem[k] = wp[k] - rp[k];
         pos[k] = rp[k];
         total += rem[k];
      end
      ptr = start_ptr;
      while (total > 0) begin
         c = -1;
         for (int i = 1; i <= NUM_CH; i++)
            if (c < 0 && rem[(ptr + i) % NUM_CH] > 0) c = (ptr + i) % NUM_CH;
         n = (rem[c] < MAX_BURST) ? rem[c] : MAX_BURST;
         exp_g.push_back(c);
         for (int j = 0; j < n; j++) begin
            exp_q.push_back({CH_W'(c), mem[c][pos[c] % DEPTH]});
            pos[c]++;
         end
         rem[c] -= n;
         total  -= n;
         ptr = c;
      end
      model_ptr = ptr;
   endtask

   // Run until every FIFO is empty and the DUT is idle; log burst starts and idle gaps.
   task automatic run(input int budget, input bit rnd);
      int prev_g, zeros;
      bit done;
      got_g.delete();
      gap_q.delete();
      done = 1'b0;
      zeros = 0;
      prev_g = int'(grant_o);
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         @(negedge clk_i);
         if (grant_o != '0 && !$onehot(grant_o)) n_bad_grant++;
         if ($countones(ch_rdreq_o) > 1) n_bad_grant++;
         if (grant_o != '0 && prev_g == 0) begin
            got_g.push_back(oh_idx(grant_o));
            gap_q.push_back(zeros);
         end
         zeros = (grant_o == '0) ? zeros + 1 : 0;
         prev_g = int'(grant_o);
         if (ch_empty_i == '1 && !valid_o && grant_o == '0) done = 1'b1;
         else ready_i = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
      timed_out = !done;
      ready_i = 1'b1;
   endtask

   task automatic test_reset();
      srst_i = 1'b0;
      ready_i = 1'b1;
      got_q.delete();
      repeat (2) @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
      n_checks++; if (grant_o !== '0) begin n_fail++; $display("FAIL rst_grant: got %b expected 0", grant_o); end
      n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", data_o); end
      n_checks++; if (chan_o !== '0) begin n_fail++; $display("FAIL rst_chan: got %0d expected 0", chan_o); end
      n_checks++; if (ch_rdreq_o !== '0) begin n_fail++; $display("FAIL rst_rdreq: got %b expected 0", ch_rdreq_o); end
      push(2, DWIDTH'($urandom));
      repeat (2) @(negedge clk_i);
      n_checks++; if (ch_rdreq_o !== '0) begin n_fail++; $display("FAIL rst_hold_rdreq: got %b expected 0", ch_rdreq_o); end
      n_checks++; if (grant_o !== '0) begin n_fail++; $display("FAIL rst_hold_grant: got %b expected 0", grant_o); end
      srst_i = 1'b1;
      model_ptr = NUM_CH - 1;
      build_expected(model_ptr);
      run(50, 1'b0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL rst_drain: drain did not finish within budget"); end
      n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         n_fail++; $display("FAIL rst_word: got %0d words first %h expected 1 word %h", got_q.size(), got_q[0], exp_q[0]);
      end
   endtask

   task automatic test_latency();
      logic [DWIDTH-1:0] a, b;
      got_q.delete();
      @(negedge clk_i);
      a = DWIDTH'($urandom);
      b = DWIDTH'($urandom);
      push(1, a);
      push(1, b);
      build_expected(model_ptr);
      #1;
      n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL lat_t0_grant: got %b expected 0000", grant_o); end
      @(negedge clk_i);
      n_checks++; if (grant_o !== 4'b0010) begin n_fail++; $display("FAIL lat_t1_grant: got %b expected 0010", grant_o); end
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_t1_valid: got %b expected 0", valid_o); end
      n_checks++; if (ch_rdreq_o !== 4'b0010) begin n_fail++; $display("FAIL lat_t1_rdreq: got %b expected 0010", ch_rdreq_o); end
      @(negedge clk_i);
      n_checks++; if ({valid_o, chan_o, data_o} !== {1'b1, 2'd1, a}) begin
         n_fail++; $display("FAIL lat_t2_beat: got v=%b ch=%0d d=%h expected v=1 ch=1 d=%h", valid_o, chan_o, data_o, a);
      end
      @(negedge clk_i);
      n_checks++; if ({valid_o, chan_o, data_o} !== {1'b1, 2'd1, b}) begin
         n_fail++; $display("FAIL lat_t3_beat: got v=%b ch=%0d d=%h expected v=1 ch=1 d=%h", valid_o, chan_o, data_o, b);
      end
      @(negedge clk_i);
      n_checks++; if (grant_o !== '0 || valid_o !== 1'b0) begin
         n_fail++; $display("FAIL lat_t4_idle: got grant=%b valid=%b expected 0000/0", grant_o, valid_o);
      end
      n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL lat_count: got %0d words expected 2", got_q.size()); end
   endtask

   task automatic test_full_rate();
      logic [CH_W+DWIDTH-1:0] gw;
      apply_reset();
      got_q.delete();
      for (int k = 0; k < NUM_CH; k++)
         for (int j = 0; j < 6; j++) push(k, DWIDTH'($urandom));
      build_expected(model_ptr);
      run(200, 1'b0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL full_drain: drain did not finish within budget"); end
      n_checks++; if (got_q.size() != 24) begin n_fail++; $display("FAIL full_count: got %0d words expected 24", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         gw = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (gw !== exp_q[i]) begin n_fail++; $display("FAIL full_word[%0d]: got %h expected %h", i, gw, exp_q[i]); end
      end
      n_checks++; if (got_g != exp_g) begin n_fail++; $display("FAIL full_grant_order: got %p expected %p", got_g, exp_g); end
      for (int i = 1; i < gap_q.size(); i++) begin
         n_checks++; if (gap_q[i] != 1) begin n_fail++; $display("FAIL full_gap[%0d]: got %0d idle cycles expected 1", i, gap_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [DWIDTH-1:0] held_d;
      logic [CH_W-1:0]   held_c;
      logic [CH_W+DWIDTH-1:0] gw;
      int w;
      got_q.delete();
      for (int j = 0; j < 4; j++) push(0, DWIDTH'($urandom));
      for (int j = 0; j < 2; j++) push(1, DWIDTH'($urandom));
      build_expected(model_ptr);
      w = 0;
      while (!valid_o && w < 10) begin @(negedge clk_i); w++; end
      n_checks++; if (!valid_o) begin n_fail++; $display("FAIL bp_start: got valid=%b expected 1 within 10 cycles", valid_o); end
      @(negedge clk_i);
      ready_i = 1'b0;
      held_d = data_o;
      held_c = chan_o;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (ch_rdreq_o !== '0) begin n_fail++; $display("FAIL bp_rdreq[%0d]: got %b expected 0000", i, ch_rdreq_o); end
         n_checks++; if ({valid_o, chan_o, data_o} !== {1'b1, held_c, held_d}) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", i, valid_o, chan_o, data_o, held_c, held_d);
         end
         @(negedge clk_i);
      end
      ready_i = 1'b1;
      run(100, 1'b0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_drain: drain did not finish within budget"); end
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         gw = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (gw !== exp_q[i]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", i, gw, exp_q[i]); end
      end
   endtask

   task automatic test_short_drain();
      logic [CH_W+DWIDTH-1:0] gw;
      int lead;
      got_q.delete();
      for (int j = 0; j < 2; j++) push(2, DWIDTH'($urandom));
      for (int j = 0; j < 3; j++) push(3, DWIDTH'($urandom));
      push(0, DWIDTH'($urandom));
      build_expected(model_ptr);
      run(100, 1'b0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL short_drain: drain did not finish within budget"); end
      n_checks++; if (got_g.size() < 2 || got_g[0] != 2 || got_g[1] != 3) begin
         n_fail++; $display("FAIL short_grants: got %p expected first ch2 then ch3", got_g);
      end
      lead = 0;
      while (lead < got_q.size() && got_q[lead][DWIDTH +: CH_W] == 2'd2) lead++;
      n_checks++; if (lead != 2) begin n_fail++; $display("FAIL short_burst_len: got %0d ch2 words expected 2", lead); end
      for (int i = 0; i < exp_q.size(); i++) begin
         gw = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (gw !== exp_q[i]) begin n_fail++; $display("FAIL short_word[%0d]: got %h expected %h", i, gw, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [CH_W+DWIDTH-1:0] gw;
      int w;
      apply_reset();
      for (int j = 0; j < 4; j++) push(1, DWIDTH'($urandom));
      for (int j = 0; j < 3; j++) push(3, DWIDTH'($urandom));
      w = 0;
      while (!valid_o && w < 10) begin @(negedge clk_i); w++; end
      n_checks++; if (!valid_o) begin n_fail++; $display("FAIL mrst_start: got valid=%b expected 1 within 10 cycles", valid_o); end
      @(negedge clk_i);
      srst_i = 1'b0;
      #1;
      n_checks++; if (ch_rdreq_o !== '0) begin n_fail++; $display("FAIL mrst_rdreq: got %b expected 0000", ch_rdreq_o); end
      @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0 || grant_o !== '0) begin
         n_fail++; $display("FAIL mrst_clear: got valid=%b grant=%b expected 0/0000", valid_o, grant_o);
      end
      for (int j = 0; j < 2; j++) push(0, DWIDTH'($urandom));
      srst_i = 1'b1;
      got_q.delete();
      build_expected(NUM_CH - 1);
      run(100, 1'b0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL mrst_drain: drain did not finish within budget"); end
      n_checks++; if (got_g.size() < 1 || got_g[0] != 0) begin n_fail++; $display("FAIL mrst_first: got grants %p expected ch0 first", got_g); end
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mrst_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         gw = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (gw !== exp_q[i]) begin n_fail++; $display("FAIL mrst_word[%0d]: got %h expected %h", i, gw, exp_q[i]); end
      end
   endtask

   task automatic test_fairness();
      logic [DWIDTH-1:0] w2;
      logic [CH_W+DWIDTH-1:0] gw;
      int w;
      apply_reset();
      got_q.delete();
      for (int j = 0; j < 8; j++) push(0, DWIDTH'($urandom));
      w = 0;
      while (grant_o !== 4'b0001 && w < 10) begin @(negedge clk_i); w++; end
      n_checks++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL fair_start: got grant=%b expected 0001", grant_o); end
      w2 = DWIDTH'($urandom);
      push(2, w2);
      run(100, 1'b0);
      model_ptr = 0;
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL fair_drain: drain did not finish within budget"); end
      n_checks++; if (got_g.size() != 2 || got_g[0] != 2 || got_g[1] != 0) begin
         n_fail++; $display("FAIL fair_order: got grants %p expected ch2 then ch0", got_g);
      end
      gw = (got_q.size() > 4) ? got_q[4] : 'x;
      n_checks++; if (gw !== {2'd2, w2}) begin n_fail++; $display("FAIL fair_ch2_word: got %h expected %h", gw, {2'd2, w2}); end
      n_checks++; if (got_q.size() != 9) begin n_fail++; $display("FAIL fair_count: got %0d words expected 9", got_q.size()); end
   endtask

   task automatic test_random();
      logic [CH_W+DWIDTH-1:0] gw;
      for (int it = 0; it < 6; it++) begin
         got_q.delete();
         for (int k = 0; k < NUM_CH; k++) begin
            int n = $urandom_range(0, 7);
            for (int j = 0; j < n; j++) push(k, DWIDTH'($urandom));
         end
         build_expected(model_ptr);
         run(400, 1'b1);
         n_checks++; if (timed_out) begin n_fail++; $display("FAIL rnd%0d_drain: drain did not finish within budget", it); end
         n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d words expected %0d", it, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size(); i++) begin
            gw = (i < got_q.size()) ? got_q[i] : 'x;
            n_checks++; if (gw !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_word[%0d]: got %h expected %h", it, i, gw, exp_q[i]); end
         end
         n_checks++; if (got_g != exp_g) begin n_fail++; $display("FAIL rnd%0d_grants: got %p expected %p", it, got_g, exp_g); end
         for (int i = 1; i < gap_q.size(); i++) begin
            n_checks++; if (gap_q[i] != 1) begin n_fail++; $display("FAIL rnd%0d_gap[%0d]: got %0d expected 1", it, i, gap_q[i]); end
         end
      end
      n_checks++; if (n_bad_pop != 0) begin n_fail++; $display("FAIL empty_pop: got %0d pops of empty FIFO expected 0", n_bad_pop); end
      n_checks++; if (n_bad_grant != 0) begin n_fail++; $display("FAIL onehot: got %0d grant/rdreq one-hot violations expected 0", n_bad_grant); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_full_rate();
      test_backpressure();
      test_short_drain();
      test_reset_mid_burst();
      test_fairness();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
